// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the RV32I datapath/decode (slave).
// Carries decode inputs, debug handshakes and every control strobe/select the sequencer drives.
interface multicycle_control_fsm_if;
   // Decode, memory and debug inputs to the sequencer
   logic [6:0] opcode;
   logic [2:0] f3;
   logic       mem_complete;
   logic       branch_taken;
   logic       halt_req;
   logic       resume_req;

   // Control strobes and selects from the sequencer
   logic       halted;
   logic       write_pc;
   logic       write_pc_ne;
   logic       write_pc_ex;
   logic       write_ir;
   logic       write_rd;
   logic       write_csr;
   logic       mem_read;
   logic       mem_write;
   logic       addr_sel;
   logic [1:0] rd_sel;
   logic [1:0] alu_insel1;
   logic [1:0] alu_insel2;
   logic       illegal_insn;

   modport master (
      input  opcode, f3, mem_complete, branch_taken, halt_req, resume_req,
      output halted, write_pc, write_pc_ne, write_pc_ex, write_ir, write_rd, write_csr,
             mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2, illegal_insn
   );

   modport slave (
      output opcode, f3, mem_complete, branch_taken, halt_req, resume_req,
      input  halted, write_pc, write_pc_ne, write_pc_ex, write_ir, write_rd, write_csr,
             mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2, illegal_insn
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/HALT with debug halt/resume.
// Define CONTROL_FSM_ILLEGAL_TRAP_EN to trap unknown opcodes and SYSTEM f3=100 into HALT.
module multicycle_control_fsm #(
   parameter bit HALT_ON_RESET = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   multicycle_control_fsm_if.master      bus
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_HALT
   } state_e;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] ALU1_RS = 2'b00;
   localparam logic [1:0] ALU1_PC = 2'b01;
   localparam logic [1:0] ALU1_ZR = 2'b10;
   localparam logic [1:0] ALU2_RS = 2'b00;
   localparam logic [1:0] ALU2_IM = 2'b01;
   localparam logic [1:0] ALU2_IS = 2'b10;
   localparam logic [1:0] RD_ALU  = 2'b00;
   localparam logic [1:0] RD_MEM  = 2'b01;
   localparam logic [1:0] RD_CSR  = 2'b10;

   state_e     state_q, state_d;

   logic       halted_d;
   logic       pc_ne_d;
   logic       pc_ex_d;
   logic       write_ir_d;
   logic       write_rd_d;
   logic       write_csr_d;
   logic       mem_read_d;
   logic       mem_write_d;
   logic       addr_sel_d;
   logic [1:0] rd_sel_d;
   logic [1:0] alu1_d;
   logic [1:0] alu2_d;
   logic       illegal_d;
   logic       insn_done;
   logic       insn_bad;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (HALT_ON_RESET) state_q <= S_HALT;
         else               state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal written here gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      halted_d    = 1'b0;
      pc_ne_d     = 1'b0;
      pc_ex_d     = 1'b0;
      write_ir_d  = 1'b0;
      write_rd_d  = 1'b0;
      write_csr_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      addr_sel_d  = 1'b0;
      rd_sel_d    = RD_ALU;
      alu1_d      = ALU1_RS;
      alu2_d      = ALU2_RS;
      illegal_d   = 1'b0;
      insn_done   = 1'b0;
      insn_bad    = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            mem_read_d = 1'b1;
            addr_sel_d = 1'b1;
            if (bus.mem_complete) begin
               write_ir_d = 1'b1;
               state_d    = S_DECODE;
            end
         end

         S_DECODE: state_d = S_EXECUTE;

         S_EXECUTE: begin
            case (bus.opcode)
               OP_LUI: begin
                  alu1_d = ALU1_ZR; alu2_d = ALU2_IM;
                  write_rd_d = 1'b1; pc_ne_d = 1'b1; insn_done = 1'b1;
               end
               OP_AUIPC: begin
                  alu1_d = ALU1_PC; alu2_d = ALU2_IM;
                  write_rd_d = 1'b1; pc_ne_d = 1'b1; insn_done = 1'b1;
               end
               OP_IMM: begin
                  // Shift-immediates take the shamt field instead of the full immediate
                  alu2_d = (bus.f3 == 3'b001 || bus.f3 == 3'b101) ? ALU2_IS : ALU2_IM;
                  write_rd_d = 1'b1; pc_ne_d = 1'b1; insn_done = 1'b1;
               end
               OP_OP: begin
                  write_rd_d = 1'b1; pc_ne_d = 1'b1; insn_done = 1'b1;
               end
               OP_JAL: begin
                  alu1_d = ALU1_PC; alu2_d = ALU2_IM;
                  write_rd_d = 1'b1; pc_ex_d = 1'b1; insn_done = 1'b1;
               end
               OP_JALR: begin
                  alu2_d = ALU2_IM;
                  write_rd_d = 1'b1; pc_ex_d = 1'b1; insn_done = 1'b1;
               end
               OP_BRANCH: begin
                  alu1_d = ALU1_PC; alu2_d = ALU2_IM;
                  pc_ex_d = bus.branch_taken;
                  pc_ne_d = ~bus.branch_taken;
                  insn_done = 1'b1;
               end
               OP_MISC: begin
                  pc_ne_d = 1'b1; insn_done = 1'b1;
               end
               OP_SYSTEM: begin
                  if (bus.f3 == 3'b000) begin
                     state_d = S_HALT;
                  end else if (bus.f3 == 3'b100) begin
                     insn_bad = 1'b1;
                  end else begin
                     rd_sel_d = RD_CSR; write_rd_d = 1'b1; write_csr_d = 1'b1;
                     pc_ne_d = 1'b1; insn_done = 1'b1;
                  end
               end
               OP_LOAD, OP_STORE: begin
                  alu2_d  = ALU2_IM;
                  state_d = S_MEM;
               end
               default: insn_bad = 1'b1;
            endcase

`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            if (insn_bad) begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
`else
            if (insn_bad) begin
               pc_ne_d   = 1'b1;
               insn_done = 1'b1;
            end
`endif
         end

         S_MEM: begin
            alu2_d      = ALU2_IM;
            mem_read_d  = (bus.opcode == OP_LOAD);
            mem_write_d = (bus.opcode != OP_LOAD);
            if (bus.mem_complete) begin
               if (bus.opcode == OP_LOAD) begin
                  write_rd_d = 1'b1;
                  rd_sel_d   = RD_MEM;
               end
               pc_ne_d   = 1'b1;
               insn_done = 1'b1;
            end
         end

         S_HALT: begin
            halted_d = 1'b1;
            if (bus.resume_req && !bus.halt_req) state_d = S_FETCH;
         end

         default: state_d = S_FETCH;
      endcase

      // Halt requests are honoured only at instruction boundaries
      if (insn_done) state_d = bus.halt_req ? S_HALT : S_FETCH;

      if (rst) begin
         halted_d    = 1'b0;
         pc_ne_d     = 1'b0;
         pc_ex_d     = 1'b0;
         write_ir_d  = 1'b0;
         write_rd_d  = 1'b0;
         write_csr_d = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         addr_sel_d  = 1'b0;
         rd_sel_d    = RD_ALU;
         alu1_d      = ALU1_RS;
         alu2_d      = ALU2_RS;
         illegal_d   = 1'b0;
      end
   end

   assign bus.halted       = halted_d;
   assign bus.write_pc     = pc_ne_d | pc_ex_d;
   assign bus.write_pc_ne  = pc_ne_d;
   assign bus.write_pc_ex  = pc_ex_d;
   assign bus.write_ir     = write_ir_d;
   assign bus.write_rd     = write_rd_d;
   assign bus.write_csr    = write_csr_d;
   assign bus.mem_read     = mem_read_d;
   assign bus.mem_write    = mem_write_d;
   assign bus.addr_sel     = addr_sel_d;
   assign bus.rd_sel       = rd_sel_d;
   assign bus.alu_insel1   = alu1_d;
   assign bus.alu_insel2   = alu2_d;
   assign bus.illegal_insn = illegal_d;

endmodule
